// File: rtl/move_input_encoder.sv
// move_input_encoder
//   Front end for the dot-matrix game buttons. Each raw button goes through a
//   2-flop synchronizer and an independent debouncer; the debounced pair forms
//   the live move code {right, left}. A code change to a nonzero value is an
//   event, delivered to the game logic through a valid/ack handshake with a
//   sticky overrun flag.
//
//   Optional build macro: MOVE_REPEAT_EN -- when defined, a held nonzero code
//   re-fires its event REPEAT_DELAY cycles after the original event and then
//   every REPEAT_PERIOD cycles.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous, active-high
//     left       in   raw left button (async to clk)
//     right      in   raw right button (async to clk)
//     move_ack   in   consumer accepts the pending move
//     cur_state  out  [1:0] debounced live code {right, left}
//     move_valid out  pending move available
//     move_code  out  [1:0] code of the pending or last move
//     overrun    out  sticky: a pending move was overwritten

module move_input_encoder_db #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int CW              = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);
  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized level disagrees with the
  // debounced one; the terminal mismatching edge flips the level.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
      else                                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;
endmodule

module move_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       move_ack,
  output logic [1:0] cur_state,
  output logic       move_valid,
  output logic [1:0] move_code,
  output logic       overrun
);
  localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                        ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD) :
                        ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW   = $clog2(MAXP + 1);

  logic [1:0] btn;
  logic [1:0] db;
  assign btn = {right, left};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    move_input_encoder_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CW(CW)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn[g]),
      .db_o  (db[g])
    );
  end

  assign cur_state = db;

  // Previous code, for the registered change compare.
  logic [1:0] prev_q;
  logic       chg, ev_chg, rpt_fire, ev;

  assign chg    = (db != prev_q);
  assign ev_chg = chg && (db != 2'b00);

`ifdef MOVE_REPEAT_EN
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_per_q, rpt_per_d;  // 0: waiting first delay, 1: periodic

  always_comb begin
    rpt_fire  = 1'b0;
    rpt_cnt_d = rpt_cnt_q + CW'(1);
    rpt_per_d = rpt_per_q;
    if (chg || db == 2'b00) begin
      rpt_cnt_d = '0;
      rpt_per_d = 1'b0;
    end else if (rpt_per_q ? (rpt_cnt_q == CW'(REPEAT_PERIOD - 1))
                           : (rpt_cnt_q == CW'(REPEAT_DELAY - 1))) begin
      rpt_fire  = 1'b1;
      rpt_cnt_d = '0;
      rpt_per_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q <= '0;
      rpt_per_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_per_q <= rpt_per_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign ev = ev_chg | rpt_fire;

  logic       valid_q, valid_d, ovr_q, ovr_d;
  logic [1:0] code_q, code_d;

  // An event always wins over ack; it only counts as overrun when the
  // previous move was neither taken earlier nor taken on this edge.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (ev) begin
      valid_d = 1'b1;
      code_d  = db;
      if (valid_q && !move_ack) ovr_d = 1'b1;
    end else if (move_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 2'b00;
      valid_q <= 1'b0;
      code_q  <= 2'b00;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= db;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign move_valid = valid_q;
  assign move_code  = code_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_move_input_encoder.sv
module tb_move_input_encoder;
  logic       clk = 1'b0;
  logic       reset, left, right, move_ack;
  logic [1:0] cur_state, move_code;
  logic       move_valid, overrun;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  move_input_encoder #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .move_ack   (move_ack),
    .cur_state  (cur_state),
    .move_valid (move_valid),
    .move_code  (move_code),
    .overrun    (overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected move and compare it with the delivered one.
  task automatic pop_chk(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty, got code %0h", tag, move_code);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, move_valid, 1);
      chk({tag, "_code"}, move_code, e);
    end
  endtask

  task automatic ack1;
    move_ack = 1'b1;
    tick(1);
    move_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; move_ack = 1'b0;
    tick(2);
    chk("rst_cur", cur_state, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_code", move_code, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick(2);

    // Clean left press: cur at edge 6, valid at 7, ack at 9
    left = 1'b1; exp_q.push_back(2'b01);
    tick(5); chk("clean_cur5", cur_state, 0);
    tick(1); chk("clean_cur6", cur_state, 1); chk("clean_val6", move_valid, 0);
    tick(1); pop_chk("clean_e7");
    tick(1); ack1;
    chk("clean_ack_val", move_valid, 0); chk("clean_ack_code", move_code, 1);
    left = 1'b0; tick(8);
    chk("clean_rel_cur", cur_state, 0); chk("clean_rel_val", move_valid, 0);

    // Bounce: 3 high, 2 low, then held high from edge 6 -> event at edge 12
    left = 1'b1; exp_q.push_back(2'b01);
    tick(3); left = 1'b0;
    tick(2); left = 1'b1;
    tick(5); chk("bounce_cur10", cur_state, 0); chk("bounce_val10", move_valid, 0);
    tick(1); chk("bounce_cur11", cur_state, 1);
    tick(1); pop_chk("bounce_e12");
    ack1; chk("bounce_ack", move_valid, 0);
    left = 1'b0; tick(8);

    // Simultaneous press -> single 11; release left -> 10; release all -> none
    left = 1'b1; right = 1'b1; exp_q.push_back(2'b11);
    tick(6); chk("sim_val6", move_valid, 0);
    tick(1); pop_chk("sim_e7"); chk("sim_cur", cur_state, 3);
    ack1;
    left = 1'b0; exp_q.push_back(2'b10);
    tick(7); pop_chk("rel_l"); chk("rel_l_cur", cur_state, 2);
    ack1;
    right = 1'b0; tick(8);
    chk("rel_all_cur", cur_state, 0); chk("rel_all_val", move_valid, 0);
    chk("rel_all_ovr", overrun, 0);

    // Overrun: two events without ack, then third event on the ack edge
    left = 1'b1;
    tick(7); chk("ovr_first_val", move_valid, 1); chk("ovr_first_ovr", overrun, 0);
    right = 1'b1; exp_q.push_back(2'b11);
    tick(7); pop_chk("ovr_second"); chk("ovr_set", overrun, 1);
    left = 1'b0; exp_q.push_back(2'b10);
    tick(6); ack1;
    pop_chk("ack_collide"); chk("ack_collide_ovr", overrun, 1);
    ack1; chk("ack_clear", move_valid, 0);
    ack1; chk("ack_idle_val", move_valid, 0); chk("ack_idle_code", move_code, 2);

    // Reset mid-debounce while a move is pending
    right = 1'b0; tick(8);
    left = 1'b1; exp_q.push_back(2'b01);
    tick(7); pop_chk("pre_rst");
    right = 1'b1;
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("arst_cur", cur_state, 0); chk("arst_val", move_valid, 0);
    chk("arst_code", move_code, 0); chk("arst_ovr", overrun, 0);
    @(negedge clk); reset = 1'b0; exp_q.push_back(2'b11);
    tick(5); chk("post_rst_cur5", cur_state, 0);
    tick(1); chk("post_rst_cur6", cur_state, 3); chk("post_rst_val6", move_valid, 0);
    tick(1); pop_chk("post_rst_e7"); chk("post_rst_ovr", overrun, 0);
    ack1;
    left = 1'b0; right = 1'b0; tick(8);

    // Auto-repeat: hold right, ack each move
    right = 1'b1; exp_q.push_back(2'b10);
    tick(7); pop_chk("rpt_e7");
    tick(1); ack1;                     // after edge 9
`ifdef MOVE_REPEAT_EN
    tick(17); chk("rpt_26", move_valid, 0);
    exp_q.push_back(2'b10);
    tick(1); pop_chk("rpt_e27");
    ack1;                              // after edge 28
    tick(6); chk("rpt_34", move_valid, 0);
    exp_q.push_back(2'b10);
    tick(1); pop_chk("rpt_e35");
    ack1;                              // after edge 36
    tick(6); chk("rpt_42", move_valid, 0);
    exp_q.push_back(2'b10);
    tick(1); pop_chk("rpt_e43");
    ack1;
    chk("rpt_ovr", overrun, 0);
`else
    tick(36); chk("norpt_45", move_valid, 0);
    chk("norpt_code", move_code, 2);
`endif
    right = 1'b0; tick(8);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/move_input_encoder.md
# move_input_encoder

Input-side front end for the dot-matrix game. It synchronizes and debounces the raw left/right push-buttons and encodes them into the 2-bit move code used for boss/player matching (`cur_state` encoding). Each new move is delivered to the game logic through a valid/ack handshake, with overrun detection. It sits between the board buttons and the player/matching logic, in the same clock domain as the dot-matrix scanner.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 25000: consecutive stable cycles required to accept a level change; legal range 2..2^20-1.
- `REPEAT_DELAY`, 500000: held cycles before the first auto-repeat; used only with `MOVE_REPEAT_EN`.
- `REPEAT_PERIOD`, 250000: cycles between subsequent auto-repeats; used only with `MOVE_REPEAT_EN`.

Ports:
- `clk`, input, 1: system clock; all flops on rising edge.
- `reset`, input, 1: **one clock; reset is asynchronous and active-high.**
- `left`, input, 1: raw left button, active-high, asynchronous to `clk`.
- `right`, input, 1: raw right button, active-high, asynchronous to `clk`.
- `move_ack`, input, 1: consumer accepts the pending move.
- `cur_state`, output, 2: debounced live code {right_db, left_db}: 00 none, 01 left, 10 right, 11 both.
- `move_valid`, output, 1: pending move available.
- `move_code`, output, 2: code of the pending or last move.
- `overrun`, output, 1: sticky flag, set when a pending move was overwritten.

## Operation
- **Reset values:** all outputs 0, sync flops 0, debounce counters 0, debounced levels 0. Reset asserted mid-operation discards any pending move and clears `overrun`.
- **Synchronizer:** 2-flop synchronizer per button.
- **Debounce (per button, independent):**
  - A counter increments on every edge where the synchronized level ≠ debounced level.
  - The counter clears on any edge where they are equal.
  - On the edge where the counter equals `DEBOUNCE_CYCLES-1` and the mismatch persists, the debounced level toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `cur_state`.
- **Event detection:** registered compare of the previous and new `cur_state`.
  - An event fires when the code changes and the new code ≠ 00.
  - A change to 00 (release) fires no event.
  - 01→11 fires an event with code 11; 11→10 fires with code 10.
  - Both buttons debouncing on the same edge produce a single event with code 11.
- **Handshake:**
  - On an event: `move_valid`←1, `move_code`←new code.
  - `move_ack` while `move_valid`=1 with no event on that edge: `move_valid`←0; `move_code` holds.
  - Event while `move_valid`=1 and `move_ack`=0: `move_code` overwritten, `move_valid` stays 1, `overrun`←1.
  - Event on the same edge as `move_ack`: `move_valid` stays 1 with the new code; no overrun.
  - `move_ack` while `move_valid`=0 is ignored.
- **`overrun`:** cleared only by `reset`.

## Timing
Edge 1 is the first rising edge sampling the button high, with the input held stable afterwards.
- Sync output changes at edge 2.
- `cur_state` updates at edge `DEBOUNCE_CYCLES`+2.
- `move_valid` rises at edge `DEBOUNCE_CYCLES`+3.
- Release follows the same latency for `cur_state`.
- `move_valid` falls on the edge sampling `move_ack`=1.
- Combinational input-to-output paths: none.
- Counter width: ceil(log2(max of the three parameters + 1)). No wrap is possible, because the counters clear at terminal count.

## Configuration
- `MOVE_REPEAT_EN` defined:
  - While `cur_state` is nonzero and unchanged, a repeat counter runs.
  - A repeat event (same code, same handshake/overrun rules as above) fires `REPEAT_DELAY` cycles after the original event, then every `REPEAT_PERIOD` cycles.
  - Any change of `cur_state`, or `reset`, restarts the counter.
- `MOVE_REPEAT_EN` undefined: events occur only on code changes. The repeat logic and the `REPEAT_*` parameters have no effect.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Clean left press:** raise `left` at edge 1 -> `cur_state`=01 at edge 6, `move_valid`=1 with `move_code`=01 at edge 7; ack at edge 9 -> `move_valid`=0 at edge 9.
- **Bounce filtering:** `left` high for 3 cycles, low 2, high 3 -> `cur_state` stays 00, no event. Then hold high -> event 01 after 7 edges.
- **Simultaneous press, then release:** `left` and `right` rise on the same edge -> single event, code 11. Release `left` -> event 10. Release both -> `cur_state`=00, no event.
- **Overrun and ack collision:** two events without ack -> `move_code`=second code, `overrun`=1. Third event on the same edge as ack -> `move_valid` stays 1, `overrun` unchanged.
- **Reset mid-debounce:** pulse `reset` at counter=2 while `move_valid`=1 -> all outputs 0 immediately, asynchronously. After release, a fresh press needs the full 7 edges.
- **Auto-repeat (`MOVE_REPEAT_EN` defined only):** hold `right`, acking each move -> events at edges 7, 27, 35, 43. Without the macro -> only the event at edge 7.
